// File: rtl/midi_pkg.sv
// midi_pkg: shared definitions for the MIDI voice table.
//   - MIDI status nibbles and the All Notes Off controller number
//   - voice_t: one voice slot, {note, velocity}
//   - parse_state_t: byte parser states
package midi_pkg;

  localparam logic [3:0] STATUS_NOTE_OFF  = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON   = 4'h9;
  localparam logic [3:0] STATUS_CC        = 4'hB;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef struct packed {
    logic [7:0] note;
    logic [7:0] velocity;
  } voice_t;

  typedef enum logic [1:0] {
    WAIT_STATUS,
    WAIT_DATA1,
    WAIT_DATA2,
    APPLY
  } parse_state_t;

endpackage

// File: rtl/midi_voice_finder.sv
// midi_voice_finder: combinational slot search over the voice table.
// Optional feature macro: MIDI_VOICE_STEAL_EN (adds age input, oldest index).
// Ports:
//   notes_i       note field of every slot, slot i at [8*i +: 8]
//   on_i          slot active flags
//   note_i        note being searched for
//   age_i         3-bit age per slot, slot i at [3*i +: 3]   (steal build only)
//   match_valid_o/match_idx_o   an active slot holds note_i, and which one
//   free_valid_o/free_idx_o     lowest-index inactive slot
//   oldest_idx_o  largest age, lowest index on a tie         (steal build only)
module midi_voice_finder #(
  parameter int NUM_VOICES = 5,
  parameter int IDX_W      = 3
) (
  input  logic [8*NUM_VOICES-1:0] notes_i,
  input  logic [NUM_VOICES-1:0]   on_i,
  input  logic [7:0]              note_i,
`ifdef MIDI_VOICE_STEAL_EN
  input  logic [3*NUM_VOICES-1:0] age_i,
  output logic [IDX_W-1:0]        oldest_idx_o,
`endif
  output logic                    match_valid_o,
  output logic [IDX_W-1:0]        match_idx_o,
  output logic                    free_valid_o,
  output logic [IDX_W-1:0]        free_idx_o
);

  // Descending scan so the lowest matching/free index wins.
  always_comb begin
    match_valid_o = 1'b0;
    match_idx_o   = '0;
    free_valid_o  = 1'b0;
    free_idx_o    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (on_i[i] && (notes_i[8*i +: 8] == note_i)) begin
        match_valid_o = 1'b1;
        match_idx_o   = IDX_W'(i);
      end
      if (!on_i[i]) begin
        free_valid_o = 1'b1;
        free_idx_o   = IDX_W'(i);
      end
    end
  end

`ifdef MIDI_VOICE_STEAL_EN
  logic [2:0] best_age;

  // Strict compare keeps the lowest index on equal ages.
  always_comb begin
    best_age     = age_i[2:0];
    oldest_idx_o = '0;
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_i[3*i +: 3] > best_age) begin
        best_age     = age_i[3*i +: 3];
        oldest_idx_o = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/midi_voice_table.sv
// midi_voice_table: parses a raw MIDI byte stream into note events and keeps
// a NUM_VOICES-slot {note, velocity} table for the waveform combiner.
// Optional feature macro: MIDI_VOICE_STEAL_EN (age-based voice stealing).
// Ports:
//   clk_in, rst_in (async, active low)
//   midi_byte_in/midi_byte_valid_in   byte from the UART receiver
//   midi_byte_ready_out               low only during the APPLY cycle
//   overrun_out                       sticky, byte offered while not ready
//   on_array_out                      slot active flags
//   midi_burst_data_out               slot i = {note, velocity} at [16*i +: 16]
//   midi_burst_change_out             one-cycle pulse on any table change
//
// state       | meaning
// WAIT_STATUS | idle; data bytes start a message only under running status
// WAIT_DATA1  | status accepted, expecting note / controller number
// WAIT_DATA2  | expecting velocity / controller value
// APPLY       | one cycle: update table, byte input not ready
module midi_voice_table
  import midi_pkg::*;
#(
  parameter int         NUM_VOICES   = 5,
  parameter logic [3:0] MIDI_CHANNEL = 4'd0
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [7:0]                 midi_byte_in,
  input  logic                       midi_byte_valid_in,
  output logic                       midi_byte_ready_out,
  output logic                       overrun_out,
  output logic [NUM_VOICES-1:0]      on_array_out,
  output logic [16*NUM_VOICES-1:0]   midi_burst_data_out,
  output logic                       midi_burst_change_out
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  parse_state_t                  state_q;
  logic                          rs_valid_q;
  logic [3:0]                    rs_type_q;
  logic [6:0]                    data1_q, data2_q;
  voice_t [NUM_VOICES-1:0]       voices_q;
  logic [NUM_VOICES-1:0]         on_q;
  logic                          change_q, overrun_q, ready_q;

  logic [8*NUM_VOICES-1:0]       notes_flat;
  logic                          match_valid, free_valid;
  logic [IDX_W-1:0]              match_idx, free_idx;
  logic                          alloc_en;
  logic [IDX_W-1:0]              alloc_idx;

  always_comb begin
    notes_flat = '0;
    for (int i = 0; i < NUM_VOICES; i++) notes_flat[8*i +: 8] = voices_q[i].note;
  end

  logic [7:0] note_cur;
  assign note_cur = {1'b0, data1_q};

`ifdef MIDI_VOICE_STEAL_EN
  logic [2:0]              age_q [NUM_VOICES];
  logic [3*NUM_VOICES-1:0] age_flat;
  logic [IDX_W-1:0]        oldest_idx;

  always_comb begin
    age_flat = '0;
    for (int i = 0; i < NUM_VOICES; i++) age_flat[3*i +: 3] = age_q[i];
  end
`endif

  midi_voice_finder #(.NUM_VOICES(NUM_VOICES), .IDX_W(IDX_W)) u_finder (
    .notes_i       (notes_flat),
    .on_i          (on_q),
    .note_i        (note_cur),
`ifdef MIDI_VOICE_STEAL_EN
    .age_i         (age_flat),
    .oldest_idx_o  (oldest_idx),
`endif
    .match_valid_o (match_valid),
    .match_idx_o   (match_idx),
    .free_valid_o  (free_valid),
    .free_idx_o    (free_idx)
  );

  logic is_status, is_realtime, status_accept;
  logic is_note_on, is_note_off, is_cc, note_on_vel, note_release;

  assign is_status     = midi_byte_in[7];
  assign is_realtime   = (midi_byte_in[7:3] == 5'b11111);
  assign status_accept = (midi_byte_in[3:0] == MIDI_CHANNEL) &&
                         ((midi_byte_in[7:4] == STATUS_NOTE_OFF) ||
                          (midi_byte_in[7:4] == STATUS_NOTE_ON)  ||
                          (midi_byte_in[7:4] == STATUS_CC));

  assign is_note_on   = (rs_type_q == STATUS_NOTE_ON);
  assign is_note_off  = (rs_type_q == STATUS_NOTE_OFF);
  assign is_cc        = (rs_type_q == STATUS_CC);
  assign note_on_vel  = is_note_on && (data2_q != 7'd0);
  assign note_release = is_note_off || (is_note_on && (data2_q == 7'd0));

  // With stealing a note-on can always be placed; without it a full table drops it.
`ifdef MIDI_VOICE_STEAL_EN
  assign alloc_en  = note_on_vel && !match_valid;
  assign alloc_idx = free_valid ? free_idx : oldest_idx;
`else
  assign alloc_en  = note_on_vel && !match_valid && free_valid;
  assign alloc_idx = free_idx;
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= WAIT_STATUS;
      rs_valid_q <= 1'b0;
      rs_type_q  <= 4'h0;
      data1_q    <= 7'd0;
      data2_q    <= 7'd0;
      voices_q   <= '0;
      on_q       <= '0;
      change_q   <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b1;
`ifdef MIDI_VOICE_STEAL_EN
      for (int i = 0; i < NUM_VOICES; i++) age_q[i] <= 3'd0;
`endif
    end else begin
      change_q <= 1'b0;
      if (midi_byte_valid_in && !ready_q) overrun_q <= 1'b1;

      if (state_q == APPLY) begin
        state_q <= WAIT_STATUS;
        ready_q <= 1'b1;
        if (note_on_vel && match_valid) begin
          voices_q[match_idx].velocity <= {1'b0, data2_q};
          change_q                     <= 1'b1;
        end else if (alloc_en) begin
          voices_q[alloc_idx].note     <= note_cur;
          voices_q[alloc_idx].velocity <= {1'b0, data2_q};
          on_q[alloc_idx]              <= 1'b1;
          change_q                     <= 1'b1;
`ifdef MIDI_VOICE_STEAL_EN
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == alloc_idx) age_q[i] <= 3'd0;
            else if (on_q[i] && (age_q[i] != 3'd7)) age_q[i] <= age_q[i] + 3'd1;
          end
`endif
        end else if (note_release && match_valid) begin
          voices_q[match_idx] <= '0;
          on_q[match_idx]     <= 1'b0;
          change_q            <= 1'b1;
        end else if (is_cc && (data1_q == CC_ALL_NOTES_OFF)) begin
          voices_q <= '0;
          on_q     <= '0;
          change_q <= 1'b1;
        end
      end else if (midi_byte_valid_in) begin
        if (is_status) begin
          // Real-time bytes pass through without touching parser state.
          if (!is_realtime) begin
            if (status_accept) begin
              rs_valid_q <= 1'b1;
              rs_type_q  <= midi_byte_in[7:4];
              state_q    <= WAIT_DATA1;
            end else begin
              rs_valid_q <= 1'b0;
              state_q    <= WAIT_STATUS;
            end
          end
        end else begin
          case (state_q)
            WAIT_STATUS: begin
              if (rs_valid_q) begin
                data1_q <= midi_byte_in[6:0];
                state_q <= WAIT_DATA2;
              end
            end
            WAIT_DATA1: begin
              data1_q <= midi_byte_in[6:0];
              state_q <= WAIT_DATA2;
            end
            WAIT_DATA2: begin
              data2_q <= midi_byte_in[6:0];
              state_q <= APPLY;
              ready_q <= 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign midi_byte_ready_out   = ready_q;
  assign overrun_out           = overrun_q;
  assign on_array_out          = on_q;
  assign midi_burst_data_out   = voices_q;
  assign midi_burst_change_out = change_q;

endmodule

// File: tb/tb_midi_voice_table.sv
module tb_midi_voice_table;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [7:0]  midi_byte_in = 8'h00;
  logic        midi_byte_valid_in = 1'b0;
  logic        midi_byte_ready_out;
  logic        overrun_out;
  logic [4:0]  on_array_out;
  logic [79:0] midi_burst_data_out;
  logic        midi_burst_change_out;

  int tests = 0;
  int fails = 0;

  midi_voice_table #(.NUM_VOICES(5), .MIDI_CHANNEL(4'd0)) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .midi_byte_in          (midi_byte_in),
    .midi_byte_valid_in    (midi_byte_valid_in),
    .midi_byte_ready_out   (midi_byte_ready_out),
    .overrun_out           (overrun_out),
    .on_array_out          (on_array_out),
    .midi_burst_data_out   (midi_burst_data_out),
    .midi_burst_change_out (midi_burst_change_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte is sampled on the first rising edge; returns one full cycle later so
  // a completed message's change pulse is visible on return.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk_in);
    midi_byte_in       = b;
    midi_byte_valid_in = 1'b1;
    @(negedge clk_in);
    midi_byte_valid_in = 1'b0;
    @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    chk("rst_ready",   {79'd0, midi_byte_ready_out}, 80'd1);
    chk("rst_on",      {75'd0, on_array_out}, 80'd0);
    chk("rst_data",    midi_burst_data_out, 80'd0);
    chk("rst_change",  {79'd0, midi_burst_change_out}, 80'd0);
    chk("rst_overrun", {79'd0, overrun_out}, 80'd0);
    rst_in = 1'b1;

    // Basic note-on
    send_byte(8'h90); send_byte(8'h3C); send_byte(8'h64);
    chk("on1_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("on1_on",    {75'd0, on_array_out}, 80'h01);
    chk("on1_data",  midi_burst_data_out, 80'h0000_0000_0000_0000_3C64);
    @(negedge clk_in);
    chk("pulse_width", {79'd0, midi_burst_change_out}, 80'd0);

    // Running status note-on, then note-on velocity 0 as release
    send_byte(8'h40); send_byte(8'h50);
    chk("rs_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("rs_data",  midi_burst_data_out, 80'h0000_0000_0000_4050_3C64);
    chk("rs_on",    {75'd0, on_array_out}, 80'h03);
    send_byte(8'h3C); send_byte(8'h00);
    chk("off_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("off_data",  midi_burst_data_out, 80'h0000_0000_0000_4050_0000);
    chk("off_on",    {75'd0, on_array_out}, 80'h02);

    // Wrong channel ignored
    send_byte(8'h91); send_byte(8'h3C); send_byte(8'h64);
    chk("chan_pulse", {79'd0, midi_burst_change_out}, 80'd0);
    chk("chan_on",    {75'd0, on_array_out}, 80'h02);

    // Real-time byte mid-message
    send_byte(8'h90); send_byte(8'hF8); send_byte(8'h3C); send_byte(8'h64);
    chk("rt_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("rt_data",  midi_burst_data_out, 80'h0000_0000_0000_4050_3C64);

    // Velocity update in place, no duplicate
    send_byte(8'h3C); send_byte(8'h20);
    chk("upd_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("upd_data",  midi_burst_data_out, 80'h0000_0000_0000_4050_3C20);
    chk("upd_on",    {75'd0, on_array_out}, 80'h03);

    // Note-off with no match
    send_byte(8'h80); send_byte(8'h55); send_byte(8'h00);
    chk("nomatch_pulse", {79'd0, midi_burst_change_out}, 80'd0);
    chk("nomatch_on",    {75'd0, on_array_out}, 80'h03);

    // Third voice, then All Notes Off
    send_byte(8'h90); send_byte(8'h45); send_byte(8'h10);
    chk("third_data", midi_burst_data_out, 80'h0000_0000_4510_4050_3C20);
    chk("third_on",   {75'd0, on_array_out}, 80'h07);
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
    chk("ano_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("ano_on",    {75'd0, on_array_out}, 80'h00);
    chk("ano_data",  midi_burst_data_out, 80'd0);

    // Other CC: no change
    send_byte(8'h07); send_byte(8'h64);
    chk("cc_other_pulse", {79'd0, midi_burst_change_out}, 80'd0);

    // Fill the table then a sixth note
    send_byte(8'h90);
    send_byte(8'h30); send_byte(8'h01);
    send_byte(8'h31); send_byte(8'h01);
    send_byte(8'h32); send_byte(8'h01);
    send_byte(8'h33); send_byte(8'h01);
    send_byte(8'h34); send_byte(8'h01);
    chk("full_on",   {75'd0, on_array_out}, 80'h1F);
    chk("full_data", midi_burst_data_out, 80'h3401_3301_3201_3101_3001);
    send_byte(8'h35); send_byte(8'h01);
`ifdef MIDI_VOICE_STEAL_EN
    chk("sixth_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("sixth_data",  midi_burst_data_out, 80'h3401_3301_3201_3101_3501);
`else
    chk("sixth_pulse", {79'd0, midi_burst_change_out}, 80'd0);
    chk("sixth_data",  midi_burst_data_out, 80'h3401_3301_3201_3101_3001);
`endif
    chk("sixth_on", {75'd0, on_array_out}, 80'h1F);

    // Clear, then a strobe during APPLY
    send_byte(8'hB0); send_byte(8'h7B); send_byte(8'h00);
    chk("clr_on", {75'd0, on_array_out}, 80'h00);
    send_byte(8'h90); send_byte(8'h3C);
    @(negedge clk_in);
    midi_byte_in = 8'h64; midi_byte_valid_in = 1'b1;
    @(negedge clk_in);
    chk("apply_ready", {79'd0, midi_byte_ready_out}, 80'd0);
    midi_byte_in = 8'h45;
    @(negedge clk_in);
    midi_byte_valid_in = 1'b0;
    chk("ovr_flag",  {79'd0, overrun_out}, 80'd1);
    chk("ovr_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("ovr_data",  midi_burst_data_out, 80'h0000_0000_0000_0000_3C64);
    send_byte(8'h30);
    chk("ovr_drop_pulse", {79'd0, midi_burst_change_out}, 80'd0);
    send_byte(8'h50);
    chk("ovr_next_pulse", {79'd0, midi_burst_change_out}, 80'd1);
    chk("ovr_next_data",  midi_burst_data_out, 80'h0000_0000_0000_3050_3C64);
    chk("ovr_sticky",     {79'd0, overrun_out}, 80'd1);

    // Async reset mid-message
    send_byte(8'h90); send_byte(8'h3C);
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_on",      {75'd0, on_array_out}, 80'h00);
    chk("arst_data",    midi_burst_data_out, 80'd0);
    chk("arst_overrun", {79'd0, overrun_out}, 80'd0);
    chk("arst_ready",   {79'd0, midi_byte_ready_out}, 80'd1);
    @(negedge clk_in);
    rst_in = 1'b1;
    send_byte(8'h64);
    send_byte(8'h20);
    chk("arst_rs_pulse", {79'd0, midi_burst_change_out}, 80'd0);
    chk("arst_rs_on",    {75'd0, on_array_out}, 80'h00);
    send_byte(8'h90); send_byte(8'h50); send_byte(8'h7F);
    chk("post_rst_data", midi_burst_data_out, 80'h0000_0000_0000_0000_507F);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
